cell_draw_sched: RTL and testbench

//  Sequences the 18x18 digit-sprite drawer across the 9x9 Sudoku grid. Accepts single-cell and

---
 rtl/cell_draw_sched.sv | 175 +++++++++++++++++
 tb/tb_cell_draw_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_draw_sched.sv
// cell_draw_sched: owns the 18x18 digit-sprite drawer and walks it over the
// 9x9 Sudoku grid. It takes single-cell and full-board redraw requests from
// game logic and reads each cell's digit from the synchronous board RAM. It
// enables the drawer and maps the drawer's local x/y onto screen coordinates.
module cell_draw_sched #(
  parameter int unsigned GRID_X0    = 70,  // screen x of cell (0,0)
  parameter int unsigned GRID_Y0    = 30,  // screen y of cell (0,0)
  parameter int unsigned CELL_PITCH = 20   // 18-pixel sprite + 2-pixel gridline
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       full_req,
  input  logic       cell_req,
  input  logic [3:0] cell_row,
  input  logic [3:0] cell_col,
  output logic [6:0] board_addr,
  input  logic [3:0] board_data,
  output logic [3:0] digit_sel,
  output logic       drw_enable,
  input  logic [4:0] drw_x,
  input  logic [4:0] drw_y,
  input  logic       drw_done,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_RD, DRAW, RELEASE, NEXT, DONE
  } state_t;

  state_t     state;
  logic       mode_full;   // 1: sweeping all 81 cells, 0: single cell
  logic [3:0] row;
  logic [3:0] col;
  logic [6:0] idx;         // linear cell index, always equal to row*9+col
  logic       pend_full;
  logic       pend_cell;
  logic [3:0] pend_row;
  logic [3:0] pend_col;
  logic       req_ok;

  // Out-of-range cell requests never reach the FSM or the pending slot.
  assign req_ok = cell_req && (cell_row <= 4'd8) && (cell_col <= 4'd8);

  // The index register drives the RAM address directly. It is loaded as the
  // FSM enters FETCH, so the RAM captures it at the end of FETCH and its data
  // is ready during WAIT_RD.
  assign board_addr = idx;

  // row*9+col as shift-and-add. This is used only when a single-cell job starts.
  function automatic logic [6:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
    return {r, 3'b000} + 7'(r) + 7'(c);
  endfunction

  // Job sequencer, request queueing and registered pixel pipeline.
  // NOTE: every register here uses <= so all reads see pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      mode_full  <= 1'b0;
      row        <= '0;
      col        <= '0;
      idx        <= '0;
      pend_full  <= 1'b0;
      pend_cell  <= 1'b0;
      pend_row   <= '0;
      pend_col   <= '0;
      digit_sel  <= '0;
      drw_enable <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Pixel pipeline: one cycle behind the drawer's counters.
      if (drw_enable) begin
        vga_x <= 9'(GRID_X0) + 9'(col) * 9'(CELL_PITCH) + 9'(drw_x);
        vga_y <= 8'(GRID_Y0) + 8'(row) * 8'(CELL_PITCH) + 8'(drw_y);
      end
      plot <= drw_enable & ~drw_done;

      // A full request supersedes any queued cell. Once a full redraw is
      // queued, later cell requests are dropped.
      if (state != IDLE) begin
        if (full_req) begin
          pend_full <= 1'b1;
          pend_cell <= 1'b0;
        end else if (req_ok && !pend_full) begin
          pend_cell <= 1'b1;
          pend_row  <= cell_row;
          pend_col  <= cell_col;
        end
      end

      case (state)
        IDLE: begin
          if (full_req || pend_full) begin
            mode_full <= 1'b1;
            row       <= '0;
            col       <= '0;
            idx       <= '0;
            pend_full <= 1'b0;
            pend_cell <= 1'b0;
            busy      <= 1'b1;
            state     <= FETCH;
          end else if (req_ok) begin
            mode_full <= 1'b0;
            row       <= cell_row;
            col       <= cell_col;
            idx       <= cell_idx(cell_row, cell_col);
            pend_cell <= 1'b0;
            busy      <= 1'b1;
            state     <= FETCH;
          end else if (pend_cell) begin
            mode_full <= 1'b0;
            row       <= pend_row;
            col       <= pend_col;
            idx       <= cell_idx(pend_row, pend_col);
            pend_cell <= 1'b0;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: state <= WAIT_RD;
        WAIT_RD: begin
          digit_sel  <= (board_data > 4'd9) ? 4'd0 : board_data;
          drw_enable <= 1'b1;
          state      <= DRAW;
        end
        DRAW: begin
          if (drw_done) begin
            drw_enable <= 1'b0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          // drw_enable stays low here for exactly one cycle so the drawer re-inits.
          if (mode_full) begin
            state <= NEXT;
          end else begin
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        NEXT: begin
          if (row == 4'd8 && col == 4'd8) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            if (col == 4'd8) begin
              col <= '0;
              row <= row + 4'd1;
            end else begin
              col <= col + 4'd1;
            end
            idx   <= idx + 7'd1;
            state <= FETCH;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_draw_sched.sv
// Self-checking bench for cell_draw_sched. It contains a sync board RAM, an
// 18x18 drawer model and a negedge monitor. The monitor logs every drawer
// burst (address, digit, pixel correctness) and every frame_done pulse. The
// tests compare that log against job lists derived from the request rules.
module tb_cell_draw_sched;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       full_req = 1'b0;
  logic       cell_req = 1'b0;
  logic [3:0] cell_row = '0;
  logic [3:0] cell_col = '0;
  logic [6:0] board_addr;
  logic [3:0] board_data;
  logic [3:0] digit_sel;
  logic       drw_enable;
  logic [4:0] drw_x;
  logic [4:0] drw_y;
  logic       drw_done;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic       plot;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  cell_draw_sched dut (
    .clk(clk), .resetn(resetn), .full_req(full_req), .cell_req(cell_req),
    .cell_row(cell_row), .cell_col(cell_col), .board_addr(board_addr),
    .board_data(board_data), .digit_sel(digit_sel), .drw_enable(drw_enable),
    .drw_x(drw_x), .drw_y(drw_y), .drw_done(drw_done), .vga_x(vga_x),
    .vga_y(vga_y), .plot(plot), .busy(busy), .frame_done(frame_done)
  );

  // Synchronous board RAM with one cycle of read latency.
  logic [3:0] mem [0:127];
  logic [3:0] ram_q = '0;
  always @(posedge clk) ram_q <= mem[board_addr];
  assign board_data = ram_q;

  // Drawer model: row-major 18x18 sweep. Done is raised after pixel (17,17).
  // The drawer clears while disabled.
  logic [4:0] dx = '0;
  logic [4:0] dy = '0;
  logic       dd = 1'b0;
  always @(posedge clk) begin
    if (!drw_enable) begin
      dx <= '0; dy <= '0; dd <= 1'b0;
    end else if (!dd) begin
      if (dx == 5'd17 && dy == 5'd17) dd <= 1'b1;
      else if (dx == 5'd17) begin dx <= '0; dy <= dy + 5'd1; end
      else dx <= dx + 5'd1;
    end
  end
  assign drw_x = dx;
  assign drw_y = dy;
  assign drw_done = dd;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // One burst of the drawer (addr >= 0) or one frame_done pulse (addr = -1).
  typedef struct {
    int addr; int digit; int nplot; int bad; int fx; int fy; int gap;
  } ev_t;

  ev_t log_q[$];
  int  n_frames = 0;
  int  stray_plot = 0;
  int  exp_q[$];

  initial begin : monitor
    ev_t cur;
    ev_t mk;
    int  gap;
    int  ex;
    int  ey;
    bit  in_burst;
    cur = '{default: 0};
    mk = '{default: 0};
    gap = -1;
    in_burst = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        in_burst = 1'b0;
        gap = -1;
      end else begin
        if (drw_enable && !in_burst) begin
          in_burst = 1'b1;
          cur.addr = int'(board_addr); cur.digit = int'(digit_sel);
          cur.nplot = 0; cur.bad = 0; cur.fx = -1; cur.fy = -1; cur.gap = gap;
        end
        if (plot) begin
          if (!in_burst) stray_plot++;
          else begin
            ex = 70 + (cur.addr % 9) * 20 + cur.nplot % 18;
            ey = 30 + (cur.addr / 9) * 20 + cur.nplot / 18;
            if (int'(vga_x) != ex || int'(vga_y) != ey || int'(digit_sel) != cur.digit)
              cur.bad++;
            if (cur.nplot == 0) begin cur.fx = int'(vga_x); cur.fy = int'(vga_y); end
            cur.nplot++;
          end
        end
        if (!drw_enable && in_burst) begin
          if (int'(digit_sel) != cur.digit) cur.bad++;
          in_burst = 1'b0;
          log_q.push_back(cur);
          gap = 1;
        end else if (!drw_enable && gap >= 0) begin
          gap++;
        end
        if (frame_done) begin
          mk.addr = -1;
          log_q.push_back(mk);
          n_frames++;
          gap = -1;
        end
      end
    end
  end

  function automatic int ref_digit(input int a);
    return (mem[a] > 4'd9) ? 0 : int'(mem[a]);
  endfunction

  task automatic pulse_cell(input int r, input int c);
    @(negedge clk);
    cell_row = 4'(r); cell_col = 4'(c); cell_req = 1'b1;
    @(negedge clk);
    cell_req = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (n_frames < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_frames < target) check({tag, " frame timeout"}, n_frames, target);
  endtask

  task automatic compare_log(input string tag, input int lb);
    int n;
    n = log_q.size() - lb;
    check({tag, " events"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      ev_t e;
      e = log_q[lb + i];
      check($sformatf("%s[%0d] addr", tag, i), e.addr, exp_q[i]);
      if (exp_q[i] >= 0 && e.addr >= 0) begin
        check($sformatf("%s[%0d] digit", tag, i), e.digit, ref_digit(exp_q[i]));
        check($sformatf("%s[%0d] plots", tag, i), e.nplot, 324);
        check($sformatf("%s[%0d] bad pixels", tag, i), e.bad, 0);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " drw_enable"}, int'(drw_enable), 0);
    check({tag, " plot"}, int'(plot), 0);
    check({tag, " frame_done"}, int'(frame_done), 0);
    check({tag, " board_addr"}, int'(board_addr), 0);
    check({tag, " digit_sel"}, int'(digit_sel), 0);
    check({tag, " vga_x"}, int'(vga_x), 0);
    check({tag, " vga_y"}, int'(vga_y), 0);
  endtask

  typedef struct {
    int row; int col; int data; int run; int addr; int digit; int x; int y;
  } vec_t;

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[9];
    int   lb;
    int   f0;
    int   nfr;
    int   bad_gaps;
    for (int a = 0; a < 128; a++) mem[a] = '0;

    // Reset from power-up.
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("post-reset busy", int'(busy), 0);

    // Single-cell vectors: literal expected address, digit and first pixel.
    vecs[0] = '{2, 3, 5, 1, 21, 5, 130, 70};
    vecs[1] = '{0, 0, 9, 1, 0, 9, 70, 30};
    vecs[2] = '{8, 8, 12, 1, 80, 0, 230, 190};
    vecs[3] = '{4, 7, 0, 1, 43, 0, 210, 110};
    vecs[4] = '{7, 2, 15, 1, 65, 0, 110, 170};
    vecs[5] = '{5, 8, 10, 1, 53, 0, 230, 130};
    vecs[6] = '{9, 0, 12, 0, 0, 0, 0, 0};
    vecs[7] = '{0, 9, 3, 0, 0, 0, 0, 0};
    vecs[8] = '{15, 15, 7, 0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      if (vecs[i].run != 0) mem[vecs[i].row * 9 + vecs[i].col] = 4'(vecs[i].data);
      lb = log_q.size();
      f0 = n_frames;
      pulse_cell(vecs[i].row, vecs[i].col);
      if (vecs[i].run != 0) begin
        check({t, " busy during job"}, int'(busy), 1);
        wait_frames(f0 + 1, 1000, t);
        repeat (2) @(negedge clk);
        check({t, " frames"}, n_frames, f0 + 1);
        check({t, " busy after"}, int'(busy), 0);
        check({t, " events"}, log_q.size(), lb + 2);
        if (log_q.size() >= lb + 2) begin
          check({t, " board_addr"}, log_q[lb].addr, vecs[i].addr);
          check({t, " digit_sel"}, log_q[lb].digit, vecs[i].digit);
          check({t, " first x"}, log_q[lb].fx, vecs[i].x);
          check({t, " first y"}, log_q[lb].fy, vecs[i].y);
          check({t, " plots"}, log_q[lb].nplot, 324);
          check({t, " bad pixels"}, log_q[lb].bad, 0);
          check({t, " frame marker"}, log_q[lb + 1].addr, -1);
        end
      end else begin
        repeat (10) @(negedge clk);
        check({t, " ignored busy"}, int'(busy), 0);
        check({t, " ignored events"}, log_q.size(), lb);
        check({t, " ignored frames"}, n_frames, f0);
      end
    end

    // Reset in the middle of a drawing burst aborts the job for good.
    mem[30] = 4'd7;
    pulse_cell(3, 3);
    for (int k = 0; k < 40 && !plot; k++) @(negedge clk);
    check("mid-job plot reached", int'(plot), 1);
    #2 resetn = 1'b0;
    #1 check_zero("mid-job reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    lb = log_q.size();
    f0 = n_frames;
    repeat (20) @(negedge clk);
    check("after abort busy", int'(busy), 0);
    check("after abort events", log_q.size(), lb);
    check("after abort frames", n_frames, f0);

    // Full board plus a simultaneous cell request. The simultaneous request
    // is dropped. Cell requests (1,1) then (4,4) arrive during the sweep, and
    // only (4,4) is drawn afterwards.
    for (int k = 0; k < 81; k++) mem[k] = 4'(k % 10);
    lb = log_q.size();
    f0 = n_frames;
    @(negedge clk);
    full_req = 1'b1; cell_req = 1'b1; cell_row = 4'd6; cell_col = 4'd6;
    @(negedge clk);
    full_req = 1'b0; cell_req = 1'b0;
    check("full busy", int'(busy), 1);
    repeat (50) @(negedge clk);
    pulse_cell(1, 1);
    repeat (1000) @(negedge clk);
    pulse_cell(4, 4);
    wait_frames(f0 + 2, 30000, "full");
    repeat (3) @(negedge clk);
    check("full frames", n_frames, f0 + 2);
    check("full busy after", int'(busy), 0);
    exp_q.delete();
    for (int k = 0; k < 81; k++) exp_q.push_back(k);
    exp_q.push_back(-1);
    exp_q.push_back(40);
    exp_q.push_back(-1);
    compare_log("full", lb);
    if (log_q.size() >= lb + 81) begin
      check("full first origin x", log_q[lb].fx, 70);
      check("full first origin y", log_q[lb].fy, 30);
      check("full last origin x", log_q[lb + 80].fx, 230);
      check("full last origin y", log_q[lb + 80].fy, 190);
      bad_gaps = 0;
      for (int k = 1; k < 81; k++) if (log_q[lb + k].gap != 4) bad_gaps++;
      check("full enable-low gaps not 4", bad_gaps, 0);
    end

    // Randomized cell traffic against the request rules.
    for (int it = 0; it < 24; it++) begin
      int r0;
      int c0;
      int nmid;
      int last;
      for (int a = 0; a < 81; a++) mem[a] = 4'($urandom_range(0, 15));
      r0 = int'($urandom_range(0, 9));
      c0 = int'($urandom_range(0, 9));
      lb = log_q.size();
      f0 = n_frames;
      exp_q.delete();
      last = -1;
      nfr = 0;
      pulse_cell(r0, c0);
      if (r0 <= 8 && c0 <= 8) begin
        exp_q.push_back(r0 * 9 + c0);
        exp_q.push_back(-1);
        nfr = 1;
        nmid = int'($urandom_range(0, 2));
        for (int m = 0; m < nmid; m++) begin
          int r;
          int c;
          repeat ($urandom_range(2, 60)) @(negedge clk);
          r = int'($urandom_range(0, 9));
          c = int'($urandom_range(0, 9));
          pulse_cell(r, c);
          if (r <= 8 && c <= 8) last = r * 9 + c;
        end
        if (last >= 0) begin
          exp_q.push_back(last);
          exp_q.push_back(-1);
          nfr = 2;
        end
        wait_frames(f0 + nfr, 1500, $sformatf("rand%0d", it));
      end else begin
        repeat (10) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check($sformatf("rand%0d busy", it), int'(busy), 0);
      check($sformatf("rand%0d frames", it), n_frames, f0 + nfr);
      compare_log($sformatf("rand%0d", it), lb);
    end

    check("stray plots", stray_plot, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
